// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: the FSM state encoding.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts 0..CLK_FREQ-1 while enabled and emits one tick per wrap.
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] count;

    // Clear wins over enable; holding while disabled preserves a paused partial count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign o_tick = i_enable && (count == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a time-unit count, decrements once per prescaler tick,
// supports pause, abort and acknowledge of the expired condition.
//
// state   | meaning
// IDLE    | no countdown active, o_remaining 0
// RUNNING | counting down, prescaler advancing
// PAUSED  | countdown frozen, prescaler holding its partial count
// EXPIRED | count reached 0, waits for i_ack (o_done pulses on entry)
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TIMER_WIDTH = 16,
    parameter int CLK_FREQ    = 100_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [TIMER_WIDTH-1:0] i_load_value,
    input  logic                   i_pause,
    input  logic                   i_abort,
    input  logic                   i_ack,
    output logic [TIMER_WIDTH-1:0] o_remaining,
    output logic                   o_busy,
    output logic                   o_expired,
    output logic                   o_done
);

    state_t                 state;
    state_t                 state_next;
    logic [TIMER_WIDTH-1:0] remaining;
    logic [TIMER_WIDTH-1:0] remaining_next;
    logic                   done;
    logic                   done_next;
    logic                   tick;
    logic                   tick_clear;
    logic                   tick_enable;

    assign tick_enable = (state == RUNNING);
    assign tick_clear  = (state == IDLE) || (state == EXPIRED) || i_start || i_abort;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (tick_clear),
        .i_enable (tick_enable),
        .o_tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            done      <= done_next;
        end
    end

    // Abort and start override everything, so a coincident tick is simply dropped.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        done_next      = 1'b0;
        if (i_abort) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else if (i_start) begin
            if (i_load_value == '0) begin
                state_next     = EXPIRED;
                remaining_next = '0;
                done_next      = 1'b1;
            end else begin
                state_next     = RUNNING;
                remaining_next = i_load_value;
            end
        end else begin
            case (state)
                RUNNING: begin
                    if (tick && (remaining <= TIMER_WIDTH'(1))) begin
                        state_next     = EXPIRED;
                        remaining_next = '0;
                        done_next      = 1'b1;
                    end else begin
                        if (tick) begin
                            remaining_next = remaining - TIMER_WIDTH'(1);
                        end
                        if (i_pause) begin
                            state_next = PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (!i_pause) begin
                        state_next = RUNNING;
                    end
                end
                EXPIRED: begin
                    if (i_ack) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_comb begin
        o_busy      = (state == RUNNING) || (state == PAUSED);
        o_expired   = (state == EXPIRED);
        o_remaining = remaining;
        o_done      = done;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TIMER_WIDTH, default 16: width of load value and remaining-time output.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clk cycles per time unit; legal range is at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 i_start  input  1  load i_load_value and begin countdown.
REQ-006 i_load_value  input  TIMER_WIDTH  countdown length in time units; sampled only when i_start is accepted.
REQ-007 i_pause  input  1  level; while high, a running countdown is frozen.
REQ-008 i_abort  input  1  cancel the countdown and return to IDLE.
REQ-009 i_ack  input  1  clear the expired condition.
REQ-010 o_remaining  output  TIMER_WIDTH  whole time units still to elapse.
REQ-011 o_busy  output  1  high in RUNNING or PAUSED.
REQ-012 o_expired  output  1  level; high in EXPIRED.
REQ-013 o_done  output  1  single-cycle pulse on entry to EXPIRED.

Function
REQ-014 States SHALL be IDLE, RUNNING, PAUSED and EXPIRED, all registered.
REQ-015 Command priority SHALL be i_abort, then i_start, then i_ack or i_pause; only the highest-priority asserted command takes effect.
REQ-016 Prescaler: counts 0..CLK_FREQ-1 and wraps; tick asserts when count==CLK_FREQ-1 in RUNNING; prescaler holds in PAUSED; prescaler clears in IDLE/EXPIRED and on an accepted i_start.
REQ-017 i_start in any state: with i_load_value=V>0 -> o_remaining<=V, RUNNING; with V==0 -> o_remaining<=0, EXPIRED, o_done pulse.
REQ-018 RUNNING, tick, o_remaining>1 -> o_remaining decrements by 1.
REQ-019 RUNNING, tick, o_remaining==1 -> o_remaining<=0, EXPIRED, o_done high for exactly the first EXPIRED cycle.
REQ-020 Latency: i_start with V accepted at edge k, no pause -> o_done high in the cycle after edge k+V*CLK_FREQ.
REQ-021 RUNNING with i_pause=1 -> PAUSED; PAUSED with i_pause=0 -> RUNNING; the partial prescaler count is preserved across the pause.
REQ-022 i_abort in any state -> IDLE, o_remaining<=0, no o_done.
REQ-023 i_ack in EXPIRED -> IDLE; i_ack in any other state has no effect.
REQ-024 A tick coinciding with an accepted i_start or i_abort SHALL be discarded.
REQ-025 o_remaining SHALL never wrap below 0; no decrement occurs outside RUNNING.
REQ-026 Outputs SHALL be registered or decoded directly from the state register: o_busy = RUNNING|PAUSED, o_expired = EXPIRED.

Reset
REQ-027 rst_n low at an edge -> IDLE, prescaler 0, o_remaining 0, o_busy 0, o_expired 0, o_done 0.
REQ-028 Reset mid-countdown SHALL abandon the count without an o_done pulse; reset overrides all inputs.

Structure
REQ-029 Package countdown_pkg SHALL hold the state enum (IDLE, RUNNING, PAUSED, EXPIRED).
REQ-030 The prescaler SHALL be sub-module tick_gen.
- Parameter: CLK_FREQ.
- Inputs: clk, rst_n, i_clear, i_enable.
- Output: o_tick.
- Counter width: $clog2(CLK_FREQ).
REQ-031 The FSM and o_remaining SHALL reside in countdown_timer.

Verification (CLK_FREQ=4, TIMER_WIDTH=8)
REQ-032 i_start with V=3 at edge 0 -> o_remaining 3,2,1,0 at edges 4,8,12; o_done high for exactly one cycle after edge 12; o_expired held until i_ack; then IDLE.
REQ-033 i_start with V=3, i_pause high for 10 cycles starting at edge 2 -> o_done delayed by exactly 10 cycles; o_remaining constant during the pause.
REQ-034 i_start with V=0 -> next cycle o_done=1, o_expired=1, o_remaining=0.
REQ-035 RUNNING with remaining 2, then i_start with V=5 -> o_remaining=5, prescaler restarts, o_done 20 cycles later; i_abort and i_start asserted together -> IDLE.
REQ-036 rst_n low for one edge during RUNNING -> all outputs 0 next cycle; no o_done ever pulses.
